// File: rtl/pi_bus_master.sv
// rtl/pi_bus_master.sv - buffered command master for the processor-interface register bus
// Commands queue in a small FIFO; a single FSM sequences setup, strobe, read latency, response and interrupt ack.
module pi_bus_master #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter int                CMD_DEPTH = 4,
  parameter int                SETUP_CYC = 1,
  parameter int                RD_LAT    = 0,
  parameter logic [ADDR_W-1:0] IRQ_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq_en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_irq,
  output logic              pi_blk_sel,
  output logic [ADDR_W-1:0] pi_addr,
  output logic              pi_wr_en,
  output logic              pi_rd_en,
  output logic [DATA_W-1:0] pi_wr_data,
  input  logic [DATA_W-1:0] pi_rd_data,
  input  logic              interrupt,
  output logic              interrupt_ack,
  output logic              busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(SETUP_CYC + 8);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] RDLAT_LD = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RDWAIT, RESP, ACK} state_e;

  state_e state_q, state_d;

  logic [ENT_W-1:0] mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full_q;
  logic             push, pop, take_irq, empty;
  logic [ENT_W-1:0] head;

  logic              cur_wr_q, irq_q, irq_armed_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [ADDR_W-1:0] pi_addr_q;
  logic [DATA_W-1:0] pi_wr_data_q, rsp_rdata_q;
  logic              rsp_irq_q;
  logic              pi_blk_sel_q, pi_wr_en_q, pi_rd_en_q, rsp_valid_q, ack_q;
  logic              pi_blk_sel_d, pi_wr_en_d, pi_rd_en_d, rsp_valid_d, ack_d;

  assign push      = cmd_valid && !full_q;
  assign empty     = (cnt_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = !full_q;
  assign busy      = (state_q != IDLE) || !empty;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == (PTR_W+1)'(CMD_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Interrupt wins over queued commands so a status read is never starved.
  always_comb begin
    state_d  = state_q;
    take_irq = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_en && interrupt && irq_armed_q) begin
          take_irq = 1'b1;
          state_d  = SETUP;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:  if (cyc_q == '0) state_d = STROBE;
      STROBE: begin
        if (cur_wr_q)         state_d = IDLE;
        else if (RD_LAT == 0) state_d = RESP;
        else                  state_d = RDWAIT;
      end
      RDWAIT: if (cyc_q == '0) state_d = RESP;
      RESP:   if (rsp_ready) state_d = irq_q ? ACK : IDLE;
      ACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so every bus pin comes straight from a flop.
  always_comb begin
    pi_blk_sel_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == RDWAIT);
    pi_wr_en_d   = (state_d == STROBE) && cur_wr_q;
    pi_rd_en_d   = (state_d == STROBE) && !cur_wr_q;
    rsp_valid_d  = (state_d == RESP);
    ack_d        = (state_d == ACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_wr_q     <= 1'b0;
      irq_q        <= 1'b0;
      irq_armed_q  <= 1'b1;
      cyc_q        <= '0;
      pi_addr_q    <= '0;
      pi_wr_data_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_irq_q    <= 1'b0;
      pi_blk_sel_q <= 1'b0;
      pi_wr_en_q   <= 1'b0;
      pi_rd_en_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      pi_blk_sel_q <= pi_blk_sel_d;
      pi_wr_en_q   <= pi_wr_en_d;
      pi_rd_en_q   <= pi_rd_en_d;
      rsp_valid_q  <= rsp_valid_d;
      ack_q        <= ack_d;
      if (take_irq) begin
        cur_wr_q  <= 1'b0;
        irq_q     <= 1'b1;
        pi_addr_q <= IRQ_ADDR;
        cyc_q     <= SETUP_LD;
      end else if (pop) begin
        cur_wr_q  <= head[ENT_W-1];
        irq_q     <= 1'b0;
        pi_addr_q <= head[DATA_W +: ADDR_W];
        cyc_q     <= SETUP_LD;
        if (head[ENT_W-1]) pi_wr_data_q <= head[DATA_W-1:0];
      end else if (state_q == STROBE) begin
        cyc_q <= RDLAT_LD;
      end else if (cyc_q != '0) begin
        cyc_q <= cyc_q - CNT_W'(1);
      end
      if (state_d == RESP && state_q != RESP) begin
        rsp_rdata_q <= pi_rd_data;
        rsp_irq_q   <= irq_q;
      end
      // A held interrupt level is serviced once; re-arm only after it is seen low.
      if (state_q == ACK)  irq_armed_q <= 1'b0;
      else if (!interrupt) irq_armed_q <= 1'b1;
    end
  end

  assign pi_blk_sel    = pi_blk_sel_q;
  assign pi_addr       = pi_addr_q;
  assign pi_wr_en      = pi_wr_en_q;
  assign pi_rd_en      = pi_rd_en_q;
  assign pi_wr_data    = pi_wr_data_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_irq       = rsp_irq_q;
  assign interrupt_ack = ack_q;

endmodule
